// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I pipeline constants: ALU op codes, forward selects, XLEN default
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    // ALU operation codes carried on ALUControlE
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // Forward selects from the hazard unit; 2'b11 is treated like FWD_RF
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational RV32I execute ALU
//
// Ports:
//   SrcA, SrcB   operands
//   ALUControl   operation (riscv_pkg ALU_*), unknown codes give 0
//   Result       modulo-2^XLEN result
//   Zero         Result == 0
module alu
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] Result,
    output logic            Zero
);

    logic slt;

    assign slt = ($signed(SrcA) < $signed(SrcB));

    always_comb begin
        Result = '0;
        case (ALUControl)
            ALU_ADD: Result = SrcA + SrcB;
            ALU_SUB: Result = SrcA - SrcB;
            ALU_AND: Result = SrcA & SrcB;
            ALU_OR:  Result = SrcA | SrcB;
            ALU_SLT: Result = {{(XLEN-1){1'b0}}, slt};
            default: Result = '0;
        endcase
    end

    assign Zero = (Result == '0);

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32I EX stage: forwarding, ALU, branch resolve, EX/MEM register
//
// Optional feature: EXEC_STALL_EN adds StallM, which holds the EX/MEM register.
//
// Ports:
//   clk, rst                  clock, async active-high reset of EX/MEM register
//   *E control/data           ID/EX fields
//   ForwardAE, ForwardBE      forward selects (riscv_pkg FWD_*)
//   ResultW                   writeback result forward source
//   PCSrcE, PCTargetE         combinational redirect to fetch
//   *M outputs                registered EX/MEM fields
//   StallM                    (EXEC_STALL_EN only) hold EX/MEM register
module execute_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic            jumpE,
    input  logic            branchE,
    input  logic            ALUSrcE,
    input  logic [1:0]      ResultSrcE,
    input  logic [2:0]      ALUControlE,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] ImmExtE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [1:0]      ForwardAE,
    input  logic [1:0]      ForwardBE,
    input  logic [XLEN-1:0] ResultW,
`ifdef EXEC_STALL_EN
    input  logic            StallM,
`endif
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic [1:0]      ResultSrcM,
    output logic [4:0]      RdM,
    output logic [XLEN-1:0] ALUResultM,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] PCPlus4M
);

    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] WriteDataE;
    logic [XLEN-1:0] SrcBE;
    logic [XLEN-1:0] ALUResultE;
    logic            ZeroE;
    logic            capture;

`ifdef EXEC_STALL_EN
    assign capture = ~StallM;
`else
    assign capture = 1'b1;
`endif

    // FWD_MEM feeds back this stage's own registered result so that
    // back-to-back dependent ALU ops need no stall.
    always_comb begin
        SrcAE = RD1_E;
        case (ForwardAE)
            FWD_WB:  SrcAE = ResultW;
            FWD_MEM: SrcAE = ALUResultM;
            default: SrcAE = RD1_E;
        endcase
    end

    always_comb begin
        WriteDataE = RD2_E;
        case (ForwardBE)
            FWD_WB:  WriteDataE = ResultW;
            FWD_MEM: WriteDataE = ALUResultM;
            default: WriteDataE = RD2_E;
        endcase
    end

    assign SrcBE = ALUSrcE ? ImmExtE : WriteDataE;

    alu #(.XLEN(XLEN)) u_alu (
        .SrcA       (SrcAE),
        .SrcB       (SrcBE),
        .ALUControl (ALUControlE),
        .Result     (ALUResultE),
        .Zero       (ZeroE)
    );

    // beq semantics: branch taken when the compare-by-subtract is zero
    assign PCSrcE    = jumpE | (branchE & ZeroE);
    assign PCTargetE = PCE + ImmExtE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 2'b00;
            RdM        <= 5'd0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else if (capture) begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RdM        <= RdE;
            ALUResultM <= ALUResultE;
            WriteDataM <= WriteDataE;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
module tb_execute_stage;

    logic        clk;
    logic        rst;
    logic        RegWriteE, MemWriteE, jumpE, branchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, PCE, ImmExtE, PCPlus4E, ResultW;
    logic [4:0]  RdE;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallM;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int n_cmp = 0;
    int n_bad = 0;

    // reference copy of the EX/MEM register contents
    logic        m_rw, m_mw;
    logic [1:0]  m_rs;
    logic [4:0]  m_rd;
    logic [31:0] m_alu, m_wd, m_pc4;

    execute_stage #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .jumpE       (jumpE),
        .branchE     (branchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RD1_E       (RD1_E),
        .RD2_E       (RD2_E),
        .RdE         (RdE),
        .PCE         (PCE),
        .ImmExtE     (ImmExtE),
        .PCPlus4E    (PCPlus4E),
        .ForwardAE   (ForwardAE),
        .ForwardBE   (ForwardBE),
        .ResultW     (ResultW),
`ifdef EXEC_STALL_EN
        .StallM      (StallM),
`endif
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .RegWriteM   (RegWriteM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .RdM         (RdM),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .PCPlus4M    (PCPlus4M)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd5:    return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return m_alu;
        return rf;
    endfunction

    task automatic model_clear();
        m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0; m_alu = 0; m_wd = 0; m_pc4 = 0;
    endtask

    task automatic check_m(input string pfx);
        chk({pfx, "_regwrite"}, RegWriteM, m_rw);
        chk({pfx, "_memwrite"}, MemWriteM, m_mw);
        chk({pfx, "_resultsrc"}, ResultSrcM, m_rs);
        chk({pfx, "_rd"}, RdM, m_rd);
        chk({pfx, "_aluresult"}, ALUResultM, m_alu);
        chk({pfx, "_writedata"}, WriteDataM, m_wd);
        chk({pfx, "_pcplus4"}, PCPlus4M, m_pc4);
    endtask

    task automatic clear_inputs();
        RegWriteE = 0; MemWriteE = 0; jumpE = 0; branchE = 0; ALUSrcE = 0;
        ResultSrcE = 0; ALUControlE = 0; RD1_E = 0; RD2_E = 0; RdE = 0;
        PCE = 0; ImmExtE = 0; PCPlus4E = 0; ForwardAE = 0; ForwardBE = 0; ResultW = 0;
    endtask

    // Called shortly after a rising edge with inputs applied: checks the
    // combinational outputs, clocks one edge, then checks the M outputs.
    task automatic run_cycle(input string pfx);
        logic [31:0] a, wd, res;
        logic        pcs;
        #3;
        a   = ref_fwd(ForwardAE, RD1_E);
        wd  = ref_fwd(ForwardBE, RD2_E);
        res = ref_alu(ALUControlE, a, ALUSrcE ? ImmExtE : wd);
        pcs = jumpE | (branchE & (res == 32'd0));
        chk({pfx, "_pcsrc"}, PCSrcE, pcs);
        chk({pfx, "_pctarget"}, PCTargetE, PCE + ImmExtE);
        @(posedge clk);
        #1;
        if (!StallM) begin
            m_rw = RegWriteE; m_mw = MemWriteE; m_rs = ResultSrcE; m_rd = RdE;
            m_alu = res; m_wd = wd; m_pc4 = PCPlus4E;
        end
        check_m(pfx);
    endtask

    logic [31:0] sweep_exp [8];
    logic [31:0] held_alu;

    initial begin
        StallM = 0;
        clear_inputs();
        model_clear();
        rst = 1;
        #1;
        check_m("reset_init");
        @(posedge clk);
        #1;
        rst = 0;

        // load non-zero state, then reset in mid-cycle
        RegWriteE = 1; MemWriteE = 1; RdE = 5'd7; RD1_E = 32'd3; RD2_E = 32'd4; PCPlus4E = 32'h44;
        run_cycle("preload");
        #1;
        rst = 1;
        #1;
        model_clear();
        check_m("reset_async");
        chk("reset_aluresult_zero", ALUResultM, 32'd0);
        @(posedge clk);
        #1;
        rst = 0;
        clear_inputs();
        RegWriteE = 1; RD1_E = 32'd5; RD2_E = 32'd7; RdE = 5'd1;
        run_cycle("post_reset");
        chk("post_reset_add", ALUResultM, 32'd12);

        // ALU sweep with operands 0xFFFFFFFF and 1
        sweep_exp[0] = 32'h0;        sweep_exp[1] = 32'hFFFFFFFE;
        sweep_exp[2] = 32'h1;        sweep_exp[3] = 32'hFFFFFFFF;
        sweep_exp[4] = 32'h0;        sweep_exp[5] = 32'h1;
        sweep_exp[6] = 32'h0;        sweep_exp[7] = 32'h0;
        for (int op = 0; op < 8; op++) begin
            clear_inputs();
            RegWriteE = 1; RD1_E = 32'hFFFFFFFF; RD2_E = 32'd1; ALUControlE = 3'(op);
            run_cycle("sweep");
            chk($sformatf("sweep_op%0d", op), ALUResultM, sweep_exp[op]);
        end

        // forwarding from MEM: produce 0x10, then add it to 3
        clear_inputs();
        RD1_E = 32'h8; RD2_E = 32'h8;
        run_cycle("fwd_setup");
        RD1_E = 32'hDEAD; RD2_E = 32'd3; ForwardAE = 2'b10;
        run_cycle("fwd_mem");
        chk("fwd_mem_result", ALUResultM, 32'h13);
        // forwarding from WB into store data
        clear_inputs();
        MemWriteE = 1; RD2_E = 32'h55; ResultW = 32'h20; ForwardBE = 2'b01;
        run_cycle("fwd_wb");
        chk("fwd_wb_writedata", WriteDataM, 32'h20);

        // branch / jump resolution
        clear_inputs();
        PCE = 32'h100; ImmExtE = 32'hFFFFFFF0; branchE = 1; ALUControlE = 3'b001;
        RD1_E = 32'd9; RD2_E = 32'd9;
        #2;
        chk("beq_taken", PCSrcE, 1'b1);
        chk("beq_target", PCTargetE, 32'hF0);
        run_cycle("beq_taken_cyc");
        RD2_E = 32'd8;
        #2;
        chk("beq_not_taken", PCSrcE, 1'b0);
        run_cycle("beq_nt_cyc");
        jumpE = 1;
        #2;
        chk("jump_taken", PCSrcE, 1'b1);
        run_cycle("jump_cyc");

        // bubble
        clear_inputs();
        run_cycle("bubble");
        chk("bubble_regwrite", RegWriteM, 1'b0);
        chk("bubble_memwrite", MemWriteM, 1'b0);
        chk("bubble_rd", RdM, 32'd0);

        // randomized against the reference model
        for (int i = 0; i < 300; i++) begin
            RegWriteE   = 1'($urandom);
            MemWriteE   = 1'($urandom);
            jumpE       = ($urandom_range(0, 7) == 0);
            branchE     = 1'($urandom);
            ALUSrcE     = 1'($urandom);
            ResultSrcE  = 2'($urandom);
            ALUControlE = 3'($urandom);
            RD1_E       = $urandom;
            RD2_E       = $urandom_range(0, 3) == 0 ? RD1_E : $urandom;
            RdE         = 5'($urandom);
            PCE         = $urandom;
            ImmExtE     = $urandom;
            PCPlus4E    = PCE + 32'd4;
            ForwardAE   = 2'($urandom);
            ForwardBE   = 2'($urandom);
            ResultW     = $urandom;
            run_cycle("rand");
        end

`ifdef EXEC_STALL_EN
        clear_inputs();
        RegWriteE = 1; RD1_E = 32'd100; RD2_E = 32'd1; RdE = 5'd3;
        run_cycle("stall_pre");
        held_alu = ALUResultM;
        StallM = 1;
        RD1_E = 32'd200; RdE = 5'd9; MemWriteE = 1;
        run_cycle("stall_1");
        RD1_E = 32'd300;
        run_cycle("stall_2");
        chk("stall_hold_alu", ALUResultM, held_alu);
        chk("stall_hold_rd", RdM, 32'd3);
        StallM = 0;
        run_cycle("stall_release");
        chk("stall_release_alu", ALUResultM, 32'd301);
        StallM = 1;
        #2;
        rst = 1;
        #1;
        model_clear();
        check_m("stall_reset");
        @(posedge clk);
        #1;
        rst = 0;
        StallM = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
